// File: rtl/regfile_write_sched_pkg.sv
// Shared defaults and FSM state type for the register-file write scheduler.
package regfile_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } wr_state_e;

endpackage

// File: rtl/regfile_write_sched_if.sv
// Two-requester write request bundle (valid/ready handshake, address, data).
interface regfile_write_sched_if
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              wr_valid_a;
  logic              wr_valid_b;
  logic              wr_ready_a;
  logic              wr_ready_b;
  logic [ADDR_W-1:0] wr_addr_a;
  logic [ADDR_W-1:0] wr_addr_b;
  logic [DATA_W-1:0] wr_data_a;
  logic [DATA_W-1:0] wr_data_b;

  modport master (
    output wr_valid_a, wr_valid_b, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b,
    input  wr_ready_a, wr_ready_b
  );

  modport slave (
    input  wr_valid_a, wr_valid_b, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b,
    output wr_ready_a, wr_ready_b
  );

endinterface

// File: rtl/regfile_write_sched_rr_arb2.sv
// Two-way round-robin arbiter. A grant is an acceptance; priority moves to
// the other requester after every grant, and a lone requester always wins.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic valid_a,
  input  logic valid_b,
  output logic grant_a,
  output logic grant_b
);

  logic prio_b;

  assign grant_a = en & valid_a & (~prio_b | ~valid_b);
  assign grant_b = en & valid_b & ( prio_b | ~valid_a);

  // Hand priority to the requester that was not just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_b <= 1'b0;
    end else if (grant_a) begin
      prio_b <= 1'b1;
    end else if (grant_b) begin
      prio_b <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_write_sched.sv
// Register-file write scheduler: arbitrates two requesters and sequences
// each write as data setup, a one-hot set strobe, then a hold/done cycle.
// Optional build macro RF_ZERO_REG_EN: register 0 is read-only zero, so
// writes to address 0 complete normally but never raise rf_set[0].
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | ready offered, rf_data holds last value
// ST_SETUP  | rf_data driven with captured data, no strobe yet
// ST_STROBE | rf_set[addr] high for STROBE_CYCLES cycles
// ST_HOLD   | strobe released, wr_done pulse with requester id
module regfile_write_sched
  import regfile_pkg::*;
#(
  parameter int NUM_REGS      = NUM_REGS_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int STROBE_CYCLES = 1
)(
  input  logic                  clk,
  input  logic                  rst,
  regfile_write_sched_if.slave  req,
  output logic [DATA_W-1:0]     rf_data,
  output logic [NUM_REGS-1:0]   rf_set,
  output logic                  wr_done,
  output logic                  wr_done_id,
  output logic                  busy
);

  localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0] STRB_LAST = 2'(STROBE_CYCLES - 1);

  wr_state_e         state;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_id;
  logic [1:0]        strb_cnt;
  logic [NUM_REGS-1:0] set_dec;
  logic              grant_a;
  logic              grant_b;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (state == ST_IDLE),
    .valid_a (req.wr_valid_a),
    .valid_b (req.wr_valid_b),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  assign req.wr_ready_a = grant_a;
  assign req.wr_ready_b = grant_b;

  // One-hot decode of the captured address; out-of-range addresses decode to zero.
  always_comb begin
    set_dec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(cap_addr) == i) begin
        set_dec[i] = 1'b1;
      end
    end
`ifdef RF_ZERO_REG_EN
    set_dec[0] = 1'b0;
`else
    set_dec[0] = set_dec[0];
`endif
  end

  // Write sequencing FSM with registered bus, strobe and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cap_addr   <= '0;
      cap_id     <= 1'b0;
      strb_cnt   <= '0;
      rf_data    <= '0;
      rf_set     <= '0;
      wr_done    <= 1'b0;
      wr_done_id <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_a || grant_b) begin
            cap_addr <= grant_b ? req.wr_addr_b : req.wr_addr_a;
            rf_data  <= grant_b ? req.wr_data_b : req.wr_data_a;
            cap_id   <= grant_b;
            busy     <= 1'b1;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          rf_set   <= set_dec;
          strb_cnt <= STRB_LAST;
          state    <= ST_STROBE;
        end
        ST_STROBE: begin
          if (strb_cnt == 2'd0) begin
            rf_set     <= '0;
            wr_done    <= 1'b1;
            wr_done_id <= cap_id;
            state      <= ST_HOLD;
          end else begin
            strb_cnt <= strb_cnt - 2'd1;
          end
        end
        ST_HOLD: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          rf_set <= '0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
